// File: rtl/rr_priority_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : penc_pkg
//  Description : Shared definitions for the rr_priority_encoder block:
//                mode encodings and the index-width helper function.
//  Revision    : 1.0  initial release
// ============================================================================
package penc_pkg;

    // Priority mode as carried on the 'mode' input.
    typedef enum logic {
        PENC_MODE_FIXED = 1'b0,
        PENC_MODE_RR    = 1'b1
    } penc_mode_e;

    // Ceiling log2, used to size the winning-index port. Callers guarantee
    // value >= 2, so the result is always at least 1.
    function automatic int penc_clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

endpackage : penc_pkg
`default_nettype wire

// File: rtl/rr_priority_encoder_fixed_core.sv
`default_nettype none
// ============================================================================
//  Module      : penc_fixed_core
//  Description : Combinational highest-set-bit finder. Reports the index of
//                the most significant asserted request and whether any
//                request is asserted at all.
//  Revision    : 1.0  initial release
// ============================================================================
module penc_fixed_core
    import penc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = penc_clog2(N)
) (
    input  logic [N-1:0] i_req,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i_req[i]) begin
                o_idx = W'(i);
                o_any = 1'b1;
            end
        end
    end

endmodule : penc_fixed_core
`default_nettype wire

// File: rtl/rr_priority_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : rr_priority_encoder
//  Description : Registered N-to-log2(N) priority encoder with fixed
//                (highest index wins) or round-robin priority. Requests enter
//                through a valid/ready handshake; the winning index leaves
//                through a one-entry output register with its own handshake.
//  Options     : PENC_ONEHOT_EN - adds the registered out_onehot grant port.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_priority_encoder
    import penc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = penc_clog2(N)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         mode,
    input  logic [N-1:0] req,
    input  logic         req_valid,
    output logic         req_ready,
    output logic [W-1:0] out_idx,
    output logic         out_zero,
    output logic         out_valid,
    input  logic         out_ready
`ifdef PENC_ONEHOT_EN
    ,
    output logic [N-1:0] out_onehot
`endif
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [W-1:0] r_ptr;        // index of the previous winner
    logic         r_out_valid;
    logic [W-1:0] r_out_idx;
    logic         r_out_zero;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic [N-1:0] w_mask_below;
    logic [N-1:0] w_req_masked;
    logic [W-1:0] w_masked_idx;
    logic         w_masked_any;
    logic [W-1:0] w_full_idx;
    logic         w_full_any;
    logic [W-1:0] w_win_idx;
    logic         w_win_any;
    logic         w_rr_mode;
    logic         w_accept;

    // Lines strictly below the pointer. Searching these first and falling
    // back to the whole vector gives the ptr-1 .. 0, N-1 .. ptr order, and
    // the wrap is modulo N for any N since only real request lines exist.
    always_comb begin
        w_mask_below = '0;
        for (int i = 0; i < N; i++) begin
            if (i < int'(r_ptr)) begin
                w_mask_below[i] = 1'b1;
            end
        end
    end

    assign w_req_masked = req & w_mask_below;

    penc_fixed_core #(
        .N      (N)
    ) u_core_masked (
        .i_req  (w_req_masked),
        .o_idx  (w_masked_idx),
        .o_any  (w_masked_any)
    );

    penc_fixed_core #(
        .N      (N)
    ) u_core_full (
        .i_req  (req),
        .o_idx  (w_full_idx),
        .o_any  (w_full_any)
    );

    assign w_rr_mode = (penc_mode_e'(mode) == PENC_MODE_RR);

    // Pick the round-robin candidate when one exists below the pointer,
    // otherwise the plain highest-set-bit result.
    always_comb begin
        w_win_idx = w_full_idx;
        w_win_any = w_full_any;
        if (w_rr_mode && w_masked_any) begin
            w_win_idx = w_masked_idx;
        end
    end

    // Output slot is free when empty or being drained this cycle.
    assign req_ready = !r_out_valid || out_ready;
    assign w_accept  = req_valid && req_ready;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Result register: load on accept, empty on drain without accept,
    // otherwise hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_zero  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_idx   <= w_win_any ? w_win_idx : '0;
            r_out_zero  <= !w_win_any;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Pointer follows the last real winner in either mode, so switching
    // modes keeps the round-robin position; all-zero accepts leave it alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (w_accept && w_win_any) begin
            r_ptr <= w_win_idx;
        end
    end

`ifdef PENC_ONEHOT_EN
    logic [N-1:0] r_out_onehot;

    // One-hot grant loaded alongside the index; zero for an empty vector.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_onehot <= '0;
        end else if (w_accept) begin
            r_out_onehot <= w_win_any ? (N'(1) << w_win_idx) : '0;
        end
    end

    assign out_onehot = r_out_onehot;
`endif

    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign out_zero  = r_out_zero;

endmodule : rr_priority_encoder
`default_nettype wire

// File: tb/tb_rr_priority_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_priority_encoder
//  Description : Self-checking bench for rr_priority_encoder (N=8 and N=5
//                instances) against a search-order reference model.
//  Options     : PENC_ONEHOT_EN - also checks out_onehot.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rr_priority_encoder;

    logic       clk;
    logic       reset_n;

    // N = 8 instance
    logic       mode8;
    logic [7:0] req8;
    logic       rv8;
    logic       rr8;
    logic [2:0] idx8;
    logic       zero8;
    logic       ov8;
    logic       ordy8;

    // N = 5 instance
    logic       mode5;
    logic [4:0] req5;
    logic       rv5;
    logic       rr5;
    logic [2:0] idx5;
    logic       zero5;
    logic       ov5;
    logic       ordy5;

`ifdef PENC_ONEHOT_EN
    logic [7:0] oh8;
    logic [4:0] oh5;
`endif

    int errors;
    int checks;

    rr_priority_encoder #(.N(8)) u_dut8 (
        .clk        (clk),
        .reset_n    (reset_n),
        .mode       (mode8),
        .req        (req8),
        .req_valid  (rv8),
        .req_ready  (rr8),
        .out_idx    (idx8),
        .out_zero   (zero8),
        .out_valid  (ov8),
        .out_ready  (ordy8)
`ifdef PENC_ONEHOT_EN
        ,
        .out_onehot (oh8)
`endif
    );

    rr_priority_encoder #(.N(5)) u_dut5 (
        .clk        (clk),
        .reset_n    (reset_n),
        .mode       (mode5),
        .req        (req5),
        .req_valid  (rv5),
        .req_ready  (rr5),
        .out_idx    (idx5),
        .out_zero   (zero5),
        .out_valid  (ov5),
        .out_ready  (ordy5)
`ifdef PENC_ONEHOT_EN
        ,
        .out_onehot (oh5)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: walk the priority order directly. Fixed mode starts from
    // N-1; round-robin starts from ptr-1 and wraps modulo n.
    function automatic int ref_win(input logic [7:0] r, input int p,
                                   input logic md, input int n);
        int start;
        int j;
        start = md ? p : 0;
        for (int k = 1; k <= n; k++) begin
            j = (start - k + n) % n;
            if (r[j]) return j;
        end
        return 0;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        rv8     = 1'b0;
        rv5     = 1'b0;
        cycle();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        mode8 = 1'b0; req8 = '0; rv8 = 1'b0; ordy8 = 1'b1;
        mode5 = 1'b0; req5 = '0; rv5 = 1'b0; ordy5 = 1'b1;
        cycle();
        cycle();
        reset_n = 1'b1;
        #1;
        checks++;
        if (rr8 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", rr8); end
        checks++;
        if (ov8 !== 1'b0 || idx8 !== 3'd0 || zero8 !== 1'b0) begin
            errors++; $display("FAIL reset_outs: got v=%b idx=%0d z=%b expected 0/0/0", ov8, idx8, zero8);
        end
        // Load a result, hold it, then assert reset mid-cycle.
        mode8 = 1'b0; req8 = 8'h80; rv8 = 1'b1; ordy8 = 1'b1;
        cycle();
        rv8 = 1'b0; ordy8 = 1'b0;
        checks++;
        if (ov8 !== 1'b1 || idx8 !== 3'd7) begin
            errors++; $display("FAIL pre_reset_load: got v=%b idx=%0d expected 1/7", ov8, idx8);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (ov8 !== 1'b0 || idx8 !== 3'd0 || zero8 !== 1'b0) begin
            errors++; $display("FAIL async_reset: got v=%b idx=%0d z=%b expected 0/0/0", ov8, idx8, zero8);
        end
        cycle();
        reset_n = 1'b1;
        ordy8 = 1'b1;
        #1;
        checks++;
        if (rr8 !== 1'b1 || ov8 !== 1'b0 || ov5 !== 1'b0) begin
            errors++; $display("FAIL post_reset: got ready=%b v8=%b v5=%b expected 1/0/0", rr8, ov8, ov5);
        end
    endtask

    task automatic test_fixed();
        do_reset();
        mode8 = 1'b0; ordy8 = 1'b1; req8 = 8'b0010_1100; rv8 = 1'b1;
        cycle();
        rv8 = 1'b0;
        checks++;
        if (ov8 !== 1'b1 || idx8 !== 3'd5 || zero8 !== 1'b0) begin
            errors++; $display("FAIL fixed_idx: got v=%b idx=%0d z=%b expected 1/5/0", ov8, idx8, zero8);
        end
`ifdef PENC_ONEHOT_EN
        checks++;
        if (oh8 !== 8'h20) begin errors++; $display("FAIL fixed_onehot: got %h expected 20", oh8); end
`endif
        cycle();
        checks++;
        if (ov8 !== 1'b0) begin errors++; $display("FAIL fixed_drain: got v=%b expected 0", ov8); end
    endtask

    task automatic test_rr_sequence();
        int exp;
        do_reset();
        mode8 = 1'b1; ordy8 = 1'b1; req8 = 8'hFF; rv8 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cycle();
            exp = (15 - i) % 8;
            checks++;
            if (ov8 !== 1'b1 || idx8 !== 3'(exp)) begin
                errors++; $display("FAIL rr_seq[%0d]: got v=%b idx=%0d expected 1/%0d", i, ov8, idx8, exp);
            end
`ifdef PENC_ONEHOT_EN
            checks++;
            if (oh8 !== (8'd1 << exp)) begin
                errors++; $display("FAIL rr_onehot[%0d]: got %h expected %h", i, oh8, 8'd1 << exp);
            end
`endif
        end
        rv8 = 1'b0;
        cycle();
    endtask

    task automatic test_back_pressure();
        do_reset();
        mode8 = 1'b0; ordy8 = 1'b1; req8 = 8'h10; rv8 = 1'b1;
        cycle();
        ordy8 = 1'b0; req8 = 8'h40; rv8 = 1'b1;
        #1;
        checks++;
        if (rr8 !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b expected 0", rr8); end
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (ov8 !== 1'b1 || idx8 !== 3'd4 || rr8 !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d]: got v=%b idx=%0d rdy=%b expected 1/4/0", i, ov8, idx8, rr8);
            end
        end
        ordy8 = 1'b1;
        #1;
        checks++;
        if (rr8 !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", rr8); end
        cycle();
        rv8 = 1'b0;
        checks++;
        if (ov8 !== 1'b1 || idx8 !== 3'd6) begin
            errors++; $display("FAIL bp_second: got v=%b idx=%0d expected 1/6", ov8, idx8);
        end
        cycle();
        checks++;
        if (ov8 !== 1'b0) begin errors++; $display("FAIL bp_drain: got v=%b expected 0", ov8); end
    endtask

    task automatic test_all_zero();
        do_reset();
        mode8 = 1'b1; ordy8 = 1'b1; req8 = 8'h08; rv8 = 1'b1;
        cycle();
        checks++;
        if (idx8 !== 3'd3 || zero8 !== 1'b0) begin
            errors++; $display("FAIL zero_setup: got idx=%0d z=%b expected 3/0", idx8, zero8);
        end
        req8 = 8'h00;
        cycle();
        checks++;
        if (ov8 !== 1'b1 || zero8 !== 1'b1 || idx8 !== 3'd0) begin
            errors++; $display("FAIL zero_result: got v=%b z=%b idx=%0d expected 1/1/0", ov8, zero8, idx8);
        end
`ifdef PENC_ONEHOT_EN
        checks++;
        if (oh8 !== 8'h00) begin errors++; $display("FAIL zero_onehot: got %h expected 00", oh8); end
`endif
        req8 = 8'hFF;
        cycle();
        rv8 = 1'b0;
        checks++;
        if (idx8 !== 3'd2 || zero8 !== 1'b0) begin
            errors++; $display("FAIL zero_ptr_kept: got idx=%0d z=%b expected 2/0", idx8, zero8);
        end
        cycle();
    endtask

    task automatic test_n5();
        int exp;
        do_reset();
        mode5 = 1'b1; ordy5 = 1'b1; req5 = 5'b11111; rv5 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            exp = (9 - i) % 5;
            checks++;
            if (ov5 !== 1'b1 || idx5 !== 3'(exp) || zero5 !== 1'b0) begin
                errors++; $display("FAIL n5_seq[%0d]: got v=%b idx=%0d expected 1/%0d", i, ov5, idx5, exp);
            end
`ifdef PENC_ONEHOT_EN
            checks++;
            if (oh5 !== (5'd1 << exp)) begin
                errors++; $display("FAIL n5_onehot[%0d]: got %h expected %h", i, oh5, 5'd1 << exp);
            end
`endif
        end
        rv5 = 1'b0;
        cycle();
    endtask

    task automatic test_random();
        logic       m_valid;
        int         m_idx;
        logic       m_zero;
        int         m_ptr;
        logic       m_acc;
        int         m_win;
        logic [7:0] m_req;
        do_reset();
        m_valid = 1'b0; m_idx = 0; m_zero = 1'b0; m_ptr = 0;
        for (int c = 0; c < 400; c++) begin
            mode8 = 1'($urandom_range(0, 1));
            req8  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) req8 = 8'h00;
            rv8   = ($urandom_range(0, 9) < 7);
            ordy8 = ($urandom_range(0, 9) < 6);
            #1;
            checks++;
            if (rr8 !== (!m_valid || ordy8)) begin
                errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, rr8, !m_valid || ordy8);
            end
            m_acc = rv8 && (!m_valid || ordy8);
            m_req = req8;
            m_win = ref_win(m_req, m_ptr, mode8, 8);
            cycle();
            if (m_acc) begin
                m_valid = 1'b1;
                m_zero  = (m_req == 8'h00);
                m_idx   = m_zero ? 0 : m_win;
                if (!m_zero) m_ptr = m_win;
            end else if (ordy8) begin
                m_valid = 1'b0;
            end
            checks++;
            if (ov8 !== m_valid) begin
                errors++; $display("FAIL rand_valid[%0d]: got %b expected %b", c, ov8, m_valid);
            end else if (m_valid) begin
                checks++;
                if (idx8 !== 3'(m_idx) || zero8 !== m_zero) begin
                    errors++; $display("FAIL rand_result[%0d]: got idx=%0d z=%b expected %0d/%b", c, idx8, zero8, m_idx, m_zero);
                end
`ifdef PENC_ONEHOT_EN
                checks++;
                if (oh8 !== (m_zero ? 8'h00 : (8'd1 << m_idx))) begin
                    errors++; $display("FAIL rand_onehot[%0d]: got %h expected %h", c, oh8, m_zero ? 8'h00 : (8'd1 << m_idx));
                end
`endif
            end
        end
        rv8 = 1'b0;
        ordy8 = 1'b1;
        cycle();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_fixed();
        test_rr_sequence();
        test_back_pressure();
        test_all_zero();
        test_n5();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_rr_priority_encoder
`default_nettype wire
